// File: rtl/mul_booth_seq_ctrl.sv
// Sequential signed radix-4 (bit-pair) Booth multiplier with a start/busy/done
// handshake. One bit-pair of the multiplier is retired per clock, so a product
// takes WIDTH/2 iterations. The product appears on hi/lo only when it is final.
module mul_booth_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW    = 2 * WIDTH;
    localparam int ITERS = WIDTH / 2;
    localparam int CW    = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [WIDTH:0]  qsh;
    logic [PW-1:0]   msh;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   sum;
    logic [CW-1:0]   cnt;
    logic            lastiter;

    assign lastiter = (cnt == CW'(ITERS - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // Next-state logic; start is honoured only from IDLE or DONE.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (lastiter) nxt = DONE;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Booth recoding of the current triplet into an addend at full product
    // width, so that -M and 2M of the most negative multiplicand cannot overflow.
    always_comb begin
        addend = '0;
        case (qsh[2:0])
            3'b001, 3'b010: addend = msh;
            3'b011:         addend = msh << 1;
            3'b100:         addend = -(msh << 1);
            3'b101, 3'b110: addend = -msh;
            default:        addend = '0;
        endcase
        sum = acc + addend;
    end

    // State register and datapath: the multiplier shifts right and the
    // sign-extended multiplicand shifts left by one bit-pair per iteration.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            qsh   <= '0;
            msh   <= '0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        qsh <= {Q, 1'b0};
                        msh <= {{WIDTH{M[WIDTH-1]}}, M};
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= sum;
                    qsh <= qsh >> 2;
                    msh <= msh << 2;
                    cnt <= cnt + 1'b1;
                    if (lastiter) begin
                        hi <= sum[PW-1:WIDTH];
                        lo <= sum[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_booth_seq_ctrl.sv
// Self-checking bench for mul_booth_seq_ctrl: a table of known products, hand
// sequences for the handshake corner cases, and random operands checked
// against a plain signed-multiply reference.
module tb_mul_booth_seq_ctrl;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] Q;
    logic [31:0] M;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int failed;

    typedef struct {
        logic [31:0] q;
        logic [31:0] m;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs[8];

    mul_booth_seq_ctrl #(.WIDTH(32)) dut (
        .clock(clock),
        .clear(clear),
        .start(start),
        .Q(Q),
        .M(M),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] refProduct(input logic [31:0] q, input logic [31:0] m);
        longint p;
        p = longint'($signed(q)) * longint'($signed(m));
        return 64'(p);
    endfunction

    // Issues one multiply (called at a falling edge) and waits for done.
    task automatic applyStimulus(input logic [31:0] q, input logic [31:0] m,
                                 output logic [63:0] prod, output int lat,
                                 output int busyCycles, output logic overlap,
                                 output logic timedOut);
        int n;
        Q = q;
        M = m;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        Q = $urandom;
        M = $urandom;
        n = 0;
        busyCycles = 0;
        overlap = 1'b0;
        while (!done && n < 40) begin
            if (busy) busyCycles++;
            @(negedge clock);
            n++;
        end
        if (busy && done) overlap = 1'b1;
        timedOut = !done;
        prod = {hi, lo};
        lat = n + 1;
    endtask

    // Waits (bounded) for done without issuing anything.
    task automatic waitDone(output int lat, output logic timedOut);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        lat = n;
        timedOut = !done;
    endtask

    initial begin
        logic [63:0] prod;
        logic [31:0] rq;
        logic [31:0] rm;
        logic [31:0] corner[6];
        int          lat;
        int          busyCycles;
        int          doneSeen;
        logic        overlap;
        logic        timedOut;

        tests  = 0;
        failed = 0;

        vecs[0] = '{32'd7,          32'd6,          64'h0000_0000_0000_002A};
        vecs[1] = '{32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[3] = '{32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000};
        vecs[4] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
        vecs[6] = '{32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{32'd0,          32'h1234_5678,  64'h0000_0000_0000_0000};

        corner[0] = 32'h8000_0000;
        corner[1] = 32'h7FFF_FFFF;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'd0;
        corner[4] = 32'd1;
        corner[5] = 32'hAAAA_AAAA;

        clear = 1'b1;
        start = 1'b0;
        Q = '0;
        M = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset busy/done", {62'd0, busy, done}, 64'd0);
        checkOutput("reset hi/lo", {hi, lo}, 64'd0);
        clear = 1'b0;
        @(negedge clock);

        // Known products, latency, busy length and done pulse width.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].q, vecs[i].m, prod, lat, busyCycles, overlap, timedOut);
            checkOutput($sformatf("vec%0d timeout", i), {63'd0, timedOut}, 64'd0);
            checkOutput($sformatf("vec%0d product", i), prod, vecs[i].prod);
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'd17);
            checkOutput($sformatf("vec%0d busy cycles", i), 64'(busyCycles), 64'd16);
            checkOutput($sformatf("vec%0d busy&done", i), {63'd0, overlap}, 64'd0);
            @(negedge clock);
            checkOutput($sformatf("vec%0d done width", i), {63'd0, done}, 64'd0);
            checkOutput($sformatf("vec%0d hold", i), {hi, lo}, vecs[i].prod);
        end

        // A start pulse in the middle of RUN is ignored.
        Q = 32'd100;
        M = 32'hFFFF_FFF9;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        Q = 32'd9;
        M = 32'd9;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(lat, timedOut);
        checkOutput("ignored start timeout", {63'd0, timedOut}, 64'd0);
        checkOutput("ignored start product", {hi, lo}, 64'hFFFF_FFFF_FFFF_FD44);
        @(negedge clock);
        checkOutput("ignored start no requeue", {62'd0, busy, done}, 64'd0);

        // Start held through DONE launches the next op with no IDLE gap.
        Q = 32'd3;
        M = 32'd4;
        start = 1'b1;
        @(negedge clock);
        waitDone(lat, timedOut);
        checkOutput("b2b first timeout", {63'd0, timedOut}, 64'd0);
        checkOutput("b2b first product", {hi, lo}, 64'd12);
        Q = 32'd5;
        M = 32'hFFFF_FFFA;
        @(negedge clock);
        start = 1'b0;
        checkOutput("b2b no gap", {62'd0, busy, done}, 64'd2);
        waitDone(lat, timedOut);
        checkOutput("b2b second timeout", {63'd0, timedOut}, 64'd0);
        checkOutput("b2b second product", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);
        checkOutput("b2b second latency", 64'(lat + 1), 64'd17);
        @(negedge clock);

        // Clear in the middle of RUN aborts and zeroes the result.
        Q = 32'd1234;
        M = 32'd5678;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checkOutput("abort busy/done", {62'd0, busy, done}, 64'd0);
        checkOutput("abort hi/lo", {hi, lo}, 64'd0);
        doneSeen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) doneSeen++;
        end
        checkOutput("abort no done", 64'(doneSeen), 64'd0);
        applyStimulus(32'd1234, 32'd5678, prod, lat, busyCycles, overlap, timedOut);
        checkOutput("after abort product", prod, 64'd7006652);
        checkOutput("after abort latency", 64'(lat), 64'd17);
        @(negedge clock);

        // Random operands, biased occasionally towards the extreme values.
        for (int i = 0; i < 2000; i++) begin
            rq = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            rm = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            applyStimulus(rq, rm, prod, lat, busyCycles, overlap, timedOut);
            checkOutput($sformatf("rand%0d product q=%h m=%h", i, rq, rm), prod, refProduct(rq, rm));
            checkOutput($sformatf("rand%0d latency", i), 64'(lat), 64'd17);
            if (overlap || timedOut)
                checkOutput($sformatf("rand%0d handshake", i), {62'd0, overlap, timedOut}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
